load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer with read-modify-write for SB/SH.
// Ports: req_* request handshake in, resp_* response handshake out,
//        mem_* single-strobe word memory port (posted writes, valid-qualified reads).
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_enable,
    output logic [31:0] mem_addr,
    output logic        mem_write_enable,
    output logic [31:0] mem_data_in,
    input  logic        mem_data_out_v,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_RD,
        WAIT,
        ISSUE_WR,
        RESP
    } state_t;

    // WAIT gives up at the end of its TIMEOUT-th cycle.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [2:0]  r_funct3;
    logic        r_store;
    logic        r_err;
    logic [7:0]  r_cnt;

    logic        w_accept;
    logic        w_legal;
    logic        w_misal;
    logic        w_bad;
    logic        w_timeout;
    logic [31:0] w_shifted;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign req_ready  = !rst && (r_state == IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_timeout  = (r_cnt == LP_CNT_LAST);

    always_comb begin
        w_legal = 1'b0;
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !req_is_store;
            default:                w_legal = 1'b0;
        endcase
    end

    assign w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_bad   = !w_legal || w_misal;

    // Little-endian lane select: shift the addressed lane down to bit 0.
    assign w_shifted = mem_data_out >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load = 32'h0;
        unique case (r_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load = mem_data_out;
            3'b100:  w_load = {24'h0, w_shifted[7:0]};
            3'b101:  w_load = {16'h0, w_shifted[15:0]};
            default: w_load = 32'h0;
        endcase
    end

    always_comb begin
        w_merge = mem_data_out;
        if (r_funct3[1:0] == 2'b00) begin
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_next = RESP;
                    end else if (req_is_store && (req_funct3 == 3'b010)) begin
                        w_next = ISSUE_WR;
                    end else begin
                        w_next = ISSUE_RD;
                    end
                end
            end
            ISSUE_RD: w_next = WAIT;
            WAIT: begin
                if (mem_data_out_v) begin
                    w_next = r_store ? ISSUE_WR : RESP;
                end else if (w_timeout) begin
                    w_next = RESP;
                end
            end
            ISSUE_WR: w_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_funct3 <= 3'b000;
            r_store  <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= 8'h0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_funct3 <= req_funct3;
                        r_store  <= req_is_store;
                        r_rdata  <= 32'h0;
                        r_err    <= w_bad;
                    end
                end
                ISSUE_RD: r_cnt <= 8'h0;
                WAIT: begin
                    // Data arriving on the last WAIT cycle beats the timeout.
                    if (mem_data_out_v) begin
                        if (r_store) begin
                            r_wdata <= w_merge;
                        end else begin
                            r_rdata <= w_load;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'h1;
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_valid       = !rst && (r_state == RESP);
    assign resp_rdata       = resp_valid ? r_rdata : 32'h0;
    assign resp_err         = resp_valid && r_err;
    assign mem_enable       = !rst && ((r_state == ISSUE_RD) || (r_state == ISSUE_WR));
    assign mem_write_enable = !rst && (r_state == ISSUE_WR);
    assign mem_addr         = mem_enable ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mem_data_in      = mem_write_enable ? r_wdata : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a latency-
// programmable memory responder and a byte-level reference model.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_enable;
    logic [31:0] mem_addr;
    logic        mem_write_enable;
    logic [31:0] mem_data_in;
    logic        mem_data_out_v = 1'b0;
    logic [31:0] mem_data_out = 32'h0;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_is_store     (req_is_store),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_enable       (mem_enable),
        .mem_addr         (mem_addr),
        .mem_write_enable (mem_write_enable),
        .mem_data_in      (mem_data_in),
        .mem_data_out_v   (mem_data_out_v),
        .mem_data_out     (mem_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t sb[$];
    wr_t   wq[$];

    logic [31:0] mem[int];
    logic [31:0] ref_mem[int];

    function automatic logic [31:0] init_word(input int idx);
        return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] mem_rd(input int idx);
        return mem.exists(idx) ? mem[idx] : init_word(idx);
    endfunction

    function automatic logic [31:0] ref_rd(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
    endfunction

    // Memory responder: returns read data cur_lat cycles after the strobe
    // (0 = never), checks write strobes against the expected write queue.
    int          cur_lat = 1;
    bit          inject_late = 1'b0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          rd_cyc = 0;
    int          rd_cd = 0;
    int          rd_idx = 0;
    logic [31:0] exp_rd_addr = 32'h0;
    wr_t         rsp_w;

    always begin
        @(negedge clk);
        mem_data_out_v = 1'b0;
        mem_data_out = $urandom;
        if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) begin
                mem_data_out_v = 1'b1;
                mem_data_out = mem_rd(rd_idx);
            end
        end
        if (inject_late) begin
            mem_data_out_v = 1'b1;
            inject_late = 1'b0;
        end
        if (mem_enable && !mem_write_enable) begin
            rd_cnt++;
            rd_cyc = cyc;
            rd_idx = int'(mem_addr[31:2]);
            rd_cd = cur_lat;
            chk("rd_addr", mem_addr, exp_rd_addr);
        end
        if (mem_enable && mem_write_enable) begin
            wr_cnt++;
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected actual=%h required=none", mem_addr);
            end else begin
                rsp_w = wq.pop_front();
                chk("wr_addr", mem_addr, rsp_w.addr);
                chk("wr_data", mem_data_in, rsp_w.data);
            end
            mem[int'(mem_addr[31:2])] = mem_data_in;
        end
    end

    // Response monitor: compares every valid cycle (so stalls check stability),
    // pops on the handshake, checks latency on the first valid cycle.
    resp_t mon_e;
    bit    in_resp = 1'b0;

    always begin
        @(negedge clk);
        #1;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected actual=%h required=none", resp_rdata);
            end else begin
                mon_e = sb[0];
                if (!in_resp && mon_e.lat >= 0)
                    chk("resp_latency", 32'(cyc - rd_cyc), 32'(mon_e.lat));
                chk("resp_rdata", resp_rdata, mon_e.rdata);
                chk("resp_err", 32'(resp_err), 32'(mon_e.err));
                if (resp_ready) void'(sb.pop_front());
            end
            in_resp = !resp_ready;
        end else begin
            in_resp = 1'b0;
        end
    end

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"},
            32'({req_ready, resp_valid, resp_err, mem_enable, mem_write_enable}),
            32'd0);
        chk({name, "_bus"}, mem_addr | mem_data_in | resp_rdata, 32'd0);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        repeat (n) begin
            #1 chk_all_zero("rst_hold");
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("rst_rel_ready", 32'(req_ready), 32'd1);
        chk("rst_rel_other",
            32'({resp_valid, resp_err, mem_enable, mem_write_enable}), 32'd0);
        chk("rst_rel_bus", mem_addr | mem_data_in | resp_rdata, 32'd0);
    endtask

    task automatic do_req(input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int lat, input int stall);
        resp_t       e;
        wr_t         w;
        int          idx;
        int          sz;
        int          sh;
        int          n;
        int          rd0;
        int          wr0;
        int          exp_rd;
        int          exp_wr;
        bit          legal;
        bit          bad;
        bit          got;
        logic [31:0] word;
        logic [31:0] m;
        longint      v;
        longint      lim;

        idx   = int'(addr[31:2]);
        sz    = 1 << f3[1:0];
        sh    = 8 * int'(addr[1:0]);
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2})
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        bad   = !legal || ((addr % sz) != 0);
        got   = (lat >= 1) && (lat <= TMO);
        word  = ref_rd(idx);
        rd0   = rd_cnt;
        wr0   = wr_cnt;
        e.lat = -1;
        e.err = 1'b0;
        e.rdata = 32'h0;
        exp_rd = 0;
        exp_wr = 0;
        w.addr = {addr[31:2], 2'b00};
        w.data = 32'h0;

        if (bad) begin
            e.err = 1'b1;
        end else if (!st) begin
            exp_rd = 1;
            e.lat = TMO + 1;
            if (!got) begin
                e.err = 1'b1;
            end else begin
                lim = longint'(1) << (8 * sz);
                v = longint'(word >> sh) % lim;
                if (sz < 4 && !f3[2] && v >= lim / 2) v -= lim;
                e.rdata = 32'(v);
                e.lat = lat + 1;
            end
        end else if (f3 == 3'd2) begin
            exp_wr = 1;
            w.data = wd;
            wq.push_back(w);
            ref_mem[idx] = wd;
        end else begin
            exp_rd = 1;
            e.lat = TMO + 1;
            if (!got) begin
                e.err = 1'b1;
            end else begin
                exp_wr = 1;
                lim = longint'(1) << (8 * sz);
                m = 32'(lim - 1) << sh;
                w.data = (word & ~m) | ((wd << sh) & m);
                wq.push_back(w);
                ref_mem[idx] = w.data;
                e.lat = lat + 2;
            end
        end
        sb.push_back(e);
        exp_rd_addr = {addr[31:2], 2'b00};
        cur_lat = lat;

        @(negedge clk);
        req_valid = 1'b1;
        req_is_store = st;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wd;
        resp_ready = 1'b0;
        #1 chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_is_store = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        n = 0;
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            checks++;
            failures++;
            $display("FAIL resp_wait actual=no_valid required=valid");
            sb.delete();
            wq.delete();
            apply_reset(1);
            return;
        end
        repeat (stall) begin
            #1 chk("req_ready_stall", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        chk("req_ready_after", 32'(req_ready), 32'd1);
        chk("resp_valid_after", 32'(resp_valid), 32'd0);
        chk("rd_strobes", 32'(rd_cnt - rd0), 32'(exp_rd));
        chk("wr_strobes", 32'(wr_cnt - wr0), 32'(exp_wr));
    endtask

    logic [2:0] ld_codes[5];
    logic [2:0] st_codes[3];

    initial begin : stim
        int          n;
        int          rd0;
        int          wr0;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        int          lat;

        ld_codes[0] = 3'd0; ld_codes[1] = 3'd1; ld_codes[2] = 3'd2;
        ld_codes[3] = 3'd4; ld_codes[4] = 3'd5;
        st_codes[0] = 3'd0; st_codes[1] = 3'd1; st_codes[2] = 3'd2;

        mem[32'h100 >> 2] = 32'h80FF7F01;
        ref_mem[32'h100 >> 2] = 32'h80FF7F01;
        mem[32'h200 >> 2] = 32'h11223344;
        ref_mem[32'h200 >> 2] = 32'h11223344;

        apply_reset(3);

        do_req(1'b0, 3'b000, 32'h103, 32'h0, 2, 0);
        do_req(1'b0, 3'b100, 32'h103, 32'h0, 1, 0);
        do_req(1'b1, 3'b000, 32'h201, 32'hAA, 1, 0);
        do_req(1'b0, 3'b010, 32'h200, 32'h0, 3, 0);
        do_req(1'b1, 3'b010, 32'h204, 32'hDEADBEEF, 1, 0);
        do_req(1'b0, 3'b001, 32'h101, 32'h0, 1, 0);
        do_req(1'b0, 3'b011, 32'h100, 32'h0, 1, 0);
        do_req(1'b0, 3'b010, 32'h204, 32'h0, TMO, 0);

        do_req(1'b0, 3'b010, 32'h100, 32'h0, 0, 0);
        inject_late = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("late_idle_ready", 32'(req_ready), 32'd1);
            chk("late_idle_resp", 32'({resp_valid, mem_enable}), 32'd0);
        end

        do_req(1'b0, 3'b101, 32'h102, 32'h0, 2, 5);

        cur_lat = 0;
        exp_rd_addr = 32'h200;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_is_store = 1'b1;
        req_funct3 = 3'b000;
        req_addr = 32'h201;
        req_wdata = 32'h55;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (rd_cnt == rd0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rstwait_rd_strobe", 32'(rd_cnt - rd0), 32'd1);
        @(negedge clk);
        apply_reset(2);
        repeat (6) begin
            @(negedge clk);
            #1 chk("rstwait_no_resp", 32'(resp_valid), 32'd0);
        end
        chk("rstwait_no_write", 32'(wr_cnt - wr0), 32'd0);

        for (int i = 0; i < 150; i++) begin
            st = 1'($urandom);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
            else if (st) f3 = st_codes[$urandom_range(0, 2)];
            else f3 = ld_codes[$urandom_range(0, 4)];
            a = 32'h100 + 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(1 << f3[1:0]) - 32'd1);
            if ($urandom_range(0, 7) == 0) lat = ($urandom_range(0, 2) == 0) ? 0 : TMO + $urandom_range(1, 2);
            else lat = $urandom_range(1, TMO);
            do_req(st, f3, a, $urandom, lat, $urandom_range(0, 3));
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("wq_empty", 32'(wq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
